// File: rtl/regpair_sequencer_if.sv
// Bus between the register-pair sequencer, its control unit and the 8-bit register file.
// master = sequencer side; slave = control unit plus register file side.
// Optional REGPAIR_X5FLAG_EN adds the x5 undocumented-flag output.
// Control group: start, op, pair, pdin -> seq; pdout, busy, done, err <- seq.
// Regfile group: r1enb/r1add, r2enb/r2add, wrenb/waddr/wdata <- seq; r1dat, r2dat -> seq.
interface regpair_sequencer_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 3
);
  logic                    start;
  logic [1:0]              op;
  logic [ADDRSIZE-2:0]     pair;
  logic [2*DATASIZE-1:0]   pdin;
  logic [2*DATASIZE-1:0]   pdout;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    r1enb;
  logic                    r2enb;
  logic [ADDRSIZE-1:0]     r1add;
  logic [ADDRSIZE-1:0]     r2add;
  logic [DATASIZE-1:0]     r1dat;
  logic [DATASIZE-1:0]     r2dat;
  logic                    wrenb;
  logic [ADDRSIZE-1:0]     waddr;
  logic [DATASIZE-1:0]     wdata;
`ifdef REGPAIR_X5FLAG_EN
  logic                    x5;

  modport master (
    input  start, op, pair, pdin, r1dat, r2dat,
    output pdout, busy, done, err, r1enb, r2enb, r1add, r2add, wrenb, waddr, wdata, x5
  );
  modport slave (
    output start, op, pair, pdin, r1dat, r2dat,
    input  pdout, busy, done, err, r1enb, r2enb, r1add, r2add, wrenb, waddr, wdata, x5
  );
`else
  modport master (
    input  start, op, pair, pdin, r1dat, r2dat,
    output pdout, busy, done, err, r1enb, r2enb, r1add, r2add, wrenb, waddr, wdata
  );
  modport slave (
    output start, op, pair, pdin, r1dat, r2dat,
    input  pdout, busy, done, err, r1enb, r2enb, r1add, r2add, wrenb, waddr, wdata
  );
`endif
endinterface

// File: rtl/regpair_sequencer.sv
// Purpose: 16-bit pair ops (INX, DCX, LDP, STP) on the 2R/1W 8-bit register file.
// Latency: done after 5 cycles (INX/DCX) or 3 cycles (LDP/STP) from the start cycle.
// Backpressure: start is taken only in IDLE; while busy it is ignored, pair 3 pulses err.
// Ports: clk_i, rst_ni (async active-low), bus (regpair_sequencer_if.master).
// Option: REGPAIR_X5FLAG_EN adds bus.x5, the 8085 K/X5 wrap flag, updated at DONE.
module regpair_sequencer #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  regpair_sequencer_if.master   bus
);
  localparam int PW = 2 * DATASIZE;
  localparam int CW = ADDRSIZE - 1;

  localparam logic [1:0] OP_INX = 2'd0;
  localparam logic [1:0] OP_DCX = 2'd1;
  localparam logic [1:0] OP_LDP = 2'd2;
  localparam logic [1:0] OP_STP = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRLO, S_WRHI, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q;
  logic [CW-1:0]   pair_q;
  logic [PW-1:0]   tmp_q, tmp_d;
  logic [PW-1:0]   pdout_q;
  logic            err_q;
  logic            accept, reject;
  logic [ADDRSIZE-1:0] hi_addr, lo_addr;

  // The all-ones pair code (3) has no register pair behind it.
  assign accept = (state_q == S_IDLE) && bus.start && (bus.pair != {CW{1'b1}});
  assign reject = (state_q == S_IDLE) && bus.start && (bus.pair == {CW{1'b1}});

  // High byte lives in the even register, low byte in the odd one (B/C, D/E, H/L).
  assign hi_addr = {pair_q, 1'b0};
  assign lo_addr = {pair_q, 1'b1};

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (bus.op == OP_STP) ? S_WRLO : S_READ;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = (op_q == OP_LDP) ? S_DONE : S_WRLO;
      S_WRLO: state_d = S_WRHI;
      S_WRHI: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Working value: pdin for STP, read data for the others, then +/-1 in EXEC.
  always_comb begin
    tmp_d = tmp_q;
    case (state_q)
      S_IDLE: if (accept) tmp_d = bus.pdin;
      S_READ: tmp_d = {bus.r1dat, bus.r2dat};
      S_EXEC: begin
        if (op_q == OP_INX)      tmp_d = tmp_q + PW'(1);
        else if (op_q == OP_DCX) tmp_d = tmp_q - PW'(1);
      end
      default: tmp_d = tmp_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= OP_INX;
      pair_q  <= '0;
      tmp_q   <= '0;
      pdout_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= bus.op;
        pair_q <= bus.pair;
      end
      tmp_q <= tmp_d;
      err_q <= reject;
      // Loading on entry to DONE makes the result visible in the same cycle as done.
      if (state_d == S_DONE) pdout_q <= tmp_d;
    end
  end

`ifdef REGPAIR_X5FLAG_EN
  logic x5_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x5_q <= 1'b0;
    end else if (state_d == S_DONE) begin
      x5_q <= ((op_q == OP_INX) && (tmp_d == {PW{1'b0}})) ||
              ((op_q == OP_DCX) && (tmp_d == {PW{1'b1}}));
    end
  end
  assign bus.x5 = x5_q;
`endif

  assign bus.pdout = pdout_q;
  assign bus.err   = err_q;

  // Output logic: regfile ports are quiet (zero) outside their own states.
  always_comb begin
    bus.busy  = (state_q != S_IDLE);
    bus.done  = (state_q == S_DONE);
    bus.r1enb = 1'b0;
    bus.r2enb = 1'b0;
    bus.r1add = '0;
    bus.r2add = '0;
    bus.wrenb = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    case (state_q)
      S_READ: begin
        bus.r1enb = 1'b1;
        bus.r1add = hi_addr;
        bus.r2enb = 1'b1;
        bus.r2add = lo_addr;
      end
      S_WRLO: begin
        bus.wrenb = 1'b1;
        bus.waddr = lo_addr;
        bus.wdata = tmp_q[DATASIZE-1:0];
      end
      S_WRHI: begin
        bus.wrenb = 1'b1;
        bus.waddr = hi_addr;
        bus.wdata = tmp_q[PW-1:DATASIZE];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_regpair_sequencer.sv
// Directed bench for regpair_sequencer with a behavioural 8x8 register file.
// Timing: inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_regpair_sequencer;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  regpair_sequencer_if #(.DATASIZE(8), .ADDRSIZE(3)) bus ();
  regpair_sequencer #(.DATASIZE(8), .ADDRSIZE(3)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  // Register file model: combinational reads, write on rising edge; preload port for the bench.
  logic [7:0] rf [8];
  logic       pl_en = 1'b0;
  logic [2:0] pl_addr = '0;
  logic [7:0] pl_dat = '0;
  assign bus.r1dat = rf[bus.r1add];
  assign bus.r2dat = rf[bus.r2add];
  always @(posedge clk_i) begin
    if (bus.wrenb)   rf[bus.waddr] <= bus.wdata;
    else if (pl_en)  rf[pl_addr]   <= pl_dat;
  end

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Issues one operation and watches it cycle by cycle until done (bounded).
  // inj > 0 raises start with pair 3 in that busy cycle to probe the ignore path.
  task automatic do_op(input logic [1:0] op, input logic [1:0] pair, input logic [15:0] din,
                       input int inj, output int dcyc, output int nrd, output int nwr,
                       output int nerr, output int nidle, output logic [2:0] ra1,
                       output logic [2:0] ra2, output logic [2:0] wa0, output logic [7:0] wd0,
                       output logic [2:0] wa1, output logic [7:0] wd1);
    dcyc = 0; nrd = 0; nwr = 0; nerr = 0; nidle = 0;
    ra1 = '0; ra2 = '0; wa0 = '0; wd0 = '0; wa1 = '0; wd1 = '0;
    bus.start = 1'b1; bus.op = op; bus.pair = pair; bus.pdin = din;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.r1enb || bus.r2enb) begin nrd++; ra1 = bus.r1add; ra2 = bus.r2add; end
      if (bus.wrenb) begin
        if (nwr == 0) begin wa0 = bus.waddr; wd0 = bus.wdata; end
        else          begin wa1 = bus.waddr; wd1 = bus.wdata; end
        nwr++;
      end
      if (bus.err)   nerr++;
      if (!bus.busy) nidle++;
      if (bus.done) begin dcyc = c; break; end
      if (c == inj) begin bus.start = 1'b1; bus.pair = 2'd3; end
      else          bus.start = 1'b0;
      tick();
    end
    bus.start = 1'b0;
  endtask

  int dcyc, nrd, nwr, nerr, nidle;
  logic [2:0] ra1, ra2, wa0, wa1;
  logic [7:0] wd0, wd1;

  task automatic test_reset();
    #3;
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.err !== 1'b0)   begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
    checks++; if (bus.pdout !== 16'h0) begin errors++; $display("FAIL reset_pdout got %h exp 0000", bus.pdout); end
    checks++; if ({bus.r1enb, bus.r2enb, bus.wrenb} !== 3'b000)
      begin errors++; $display("FAIL reset_enables got %b exp 000", {bus.r1enb, bus.r2enb, bus.wrenb}); end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_inx_hl();
    preload(3'd4, 8'h12);
    preload(3'd5, 8'hFF);
    do_op(2'd0, 2'd2, 16'h0, 0, dcyc, nrd, nwr, nerr, nidle, ra1, ra2, wa0, wd0, wa1, wd1);
    checks++; if (dcyc !== 5) begin errors++; $display("FAIL inx_done_cycle got %0d exp 5", dcyc); end
    checks++; if (bus.pdout !== 16'h1300) begin errors++; $display("FAIL inx_pdout got %h exp 1300", bus.pdout); end
    checks++; if ({ra1, ra2} !== {3'd4, 3'd5}) begin errors++; $display("FAIL inx_read_addr got %0d/%0d exp 4/5", ra1, ra2); end
    checks++; if ({wa0, wd0, wa1, wd1} !== {3'd5, 8'h00, 3'd4, 8'h13})
      begin errors++; $display("FAIL inx_writes got %0d:%h %0d:%h exp 5:00 4:13", wa0, wd0, wa1, wd1); end
    checks++; if ({rf[4], rf[5]} !== 16'h1300) begin errors++; $display("FAIL inx_regfile got %h%h exp 1300", rf[4], rf[5]); end
    checks++; if (nidle !== 0) begin errors++; $display("FAIL inx_busy idle_cycles=%0d exp 0", nidle); end
    checks++; if ({bus.wrenb, bus.waddr, bus.wdata, bus.r1add} !== 15'h0)
      begin errors++; $display("FAIL inx_quiet_in_done got %h exp 0", {bus.wrenb, bus.waddr, bus.wdata, bus.r1add}); end
`ifdef REGPAIR_X5FLAG_EN
    checks++; if (bus.x5 !== 1'b0) begin errors++; $display("FAIL inx_x5 got %b exp 0", bus.x5); end
`endif
    tick();
  endtask

  task automatic test_dcx_bc();
    preload(3'd0, 8'h00);
    preload(3'd1, 8'h00);
    do_op(2'd1, 2'd0, 16'h0, 0, dcyc, nrd, nwr, nerr, nidle, ra1, ra2, wa0, wd0, wa1, wd1);
    checks++; if (dcyc !== 5) begin errors++; $display("FAIL dcx_done_cycle got %0d exp 5", dcyc); end
    checks++; if (bus.pdout !== 16'hFFFF) begin errors++; $display("FAIL dcx_pdout got %h exp FFFF", bus.pdout); end
    checks++; if ({wa0, wd0, wa1, wd1} !== {3'd1, 8'hFF, 3'd0, 8'hFF})
      begin errors++; $display("FAIL dcx_writes got %0d:%h %0d:%h exp 1:FF 0:FF", wa0, wd0, wa1, wd1); end
    checks++; if ({rf[0], rf[1]} !== 16'hFFFF) begin errors++; $display("FAIL dcx_regfile got %h%h exp FFFF", rf[0], rf[1]); end
`ifdef REGPAIR_X5FLAG_EN
    checks++; if (bus.x5 !== 1'b1) begin errors++; $display("FAIL dcx_x5 got %b exp 1", bus.x5); end
`endif
    tick();
  endtask

  // STP DE followed by LDP DE issued in the IDLE cycle right after DONE.
  task automatic test_back_to_back();
    do_op(2'd3, 2'd1, 16'hA55A, 0, dcyc, nrd, nwr, nerr, nidle, ra1, ra2, wa0, wd0, wa1, wd1);
    checks++; if (dcyc !== 3) begin errors++; $display("FAIL stp_done_cycle got %0d exp 3", dcyc); end
    checks++; if (nrd !== 0) begin errors++; $display("FAIL stp_no_reads got %0d exp 0", nrd); end
    checks++; if ({wa0, wd0, wa1, wd1} !== {3'd3, 8'h5A, 3'd2, 8'hA5})
      begin errors++; $display("FAIL stp_writes got %0d:%h %0d:%h exp 3:5A 2:A5", wa0, wd0, wa1, wd1); end
    checks++; if (bus.pdout !== 16'hA55A) begin errors++; $display("FAIL stp_pdout got %h exp A55A", bus.pdout); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", bus.busy); end
    do_op(2'd2, 2'd1, 16'h0, 0, dcyc, nrd, nwr, nerr, nidle, ra1, ra2, wa0, wd0, wa1, wd1);
    checks++; if (dcyc !== 3) begin errors++; $display("FAIL ldp_done_cycle got %0d exp 3", dcyc); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL ldp_no_writes got %0d exp 0", nwr); end
    checks++; if ({ra1, ra2} !== {3'd2, 3'd3}) begin errors++; $display("FAIL ldp_read_addr got %0d/%0d exp 2/3", ra1, ra2); end
    checks++; if (bus.pdout !== 16'hA55A) begin errors++; $display("FAIL ldp_pdout got %h exp A55A", bus.pdout); end
`ifdef REGPAIR_X5FLAG_EN
    checks++; if (bus.x5 !== 1'b0) begin errors++; $display("FAIL ldp_x5 got %b exp 0", bus.x5); end
`endif
    tick();
  endtask

  task automatic test_err_and_ignore();
    bus.start = 1'b1; bus.op = 2'd0; bus.pair = 2'd3;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", bus.err); end
    checks++; if ({bus.busy, bus.done, bus.r1enb, bus.wrenb} !== 4'b0000)
      begin errors++; $display("FAIL err_no_activity got %b exp 0000", {bus.busy, bus.done, bus.r1enb, bus.wrenb}); end
    tick();
    checks++; if ({bus.err, bus.busy} !== 2'b00) begin errors++; $display("FAIL err_one_cycle got %b exp 00", {bus.err, bus.busy}); end
    // INX DE (A55A) with a stray start raised mid-operation: must be ignored.
    do_op(2'd0, 2'd1, 16'h0, 2, dcyc, nrd, nwr, nerr, nidle, ra1, ra2, wa0, wd0, wa1, wd1);
    checks++; if (dcyc !== 5) begin errors++; $display("FAIL ignore_done_cycle got %0d exp 5", dcyc); end
    checks++; if (nerr !== 0) begin errors++; $display("FAIL ignore_no_err got %0d exp 0", nerr); end
    checks++; if (bus.pdout !== 16'hA55B) begin errors++; $display("FAIL ignore_pdout got %h exp A55B", bus.pdout); end
    checks++; if ({rf[2], rf[3]} !== 16'hA55B) begin errors++; $display("FAIL ignore_regfile got %h%h exp A55B", rf[2], rf[3]); end
    tick();
    checks++; if ({bus.busy, bus.err} !== 2'b00) begin errors++; $display("FAIL ignore_after got %b exp 00", {bus.busy, bus.err}); end
  endtask

  // INX BC from 01FF: reset lands in WRHI, after C=00 was written but before B.
  task automatic test_async_reset_midop();
    int c;
    preload(3'd0, 8'h01);
    preload(3'd1, 8'hFF);
    bus.start = 1'b1; bus.op = 2'd0; bus.pair = 2'd0;
    tick();
    bus.start = 1'b0;
    c = 1;
    while (c < 4) begin tick(); c++; end
    checks++; if ({bus.wrenb, bus.waddr} !== 4'b1000)
      begin errors++; $display("FAIL midop_in_wrhi got %b exp 1000", {bus.wrenb, bus.waddr}); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.done, bus.err, bus.wrenb, bus.r1enb} !== 5'b0)
      begin errors++; $display("FAIL midop_reset_ctrl got %b exp 00000", {bus.busy, bus.done, bus.err, bus.wrenb, bus.r1enb}); end
    checks++; if ({bus.pdout, bus.waddr, bus.wdata} !== 27'h0)
      begin errors++; $display("FAIL midop_reset_data got %h exp 0", {bus.pdout, bus.waddr, bus.wdata}); end
    tick();
    rst_ni = 1'b1;
    tick();
    checks++; if ({rf[0], rf[1]} !== 16'h0100) begin errors++; $display("FAIL midop_half_written got %h%h exp 0100", rf[0], rf[1]); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midop_idle_after got %b exp 0", bus.busy); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.pair = 2'd0; bus.pdin = 16'h0;
    test_reset();
    test_inx_hl();
    test_dcx_bc();
    test_back_to_back();
    test_err_and_ignore();
    test_async_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
